pipe_stage_reg: RTL

- Parametrised pipeline-stage register for the in-order core.
- Replaces per-stage hand-written registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block carrying a packed payload bus plus a valid bit.
- Driven by the shared ctrl stall vector and a flush line; inserts bubbles, holds, or advances the payload.
- Keeps saturating hold and bubble counters for performance analysis.

---
 rtl/pipe_stage_reg.sv | 119 +++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register: packed payload plus valid bit, steered by the ctrl stall vector and flush.
// Saturating hold/bubble counters record how often the stage stalled.
module pipe_stage_reg #(
  parameter int                 DATA_W    = 64,
  parameter int                 STALL_W   = 6,
  parameter int                 STAGE     = 2,
  parameter logic [DATA_W-1:0]  NOP_VALUE = {DATA_W{1'b0}},
  parameter int                 CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STALL_W-1:0] stall_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              cnt_clr_i,
  output logic [CNT_W-1:0]  hold_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  // Per-cycle action of the stage; decoded combinationally, applied at the clock edge.
  typedef enum logic [1:0] {
    ACT_ADVANCE = 2'd0,
    ACT_HOLD    = 2'd1,
    ACT_BUBBLE  = 2'd2,
    ACT_FLUSH   = 2'd3
  } act_e;

  localparam bit HAS_DN = (STAGE + 1 < STALL_W);

  logic up;
  logic dn;
  act_e act;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [CNT_W-1:0]  hold_cnt_q,   hold_cnt_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
  logic              unused_stall;

  assign up = stall_i[STAGE];

  // The last stage has no downstream stall bit, so it can only bubble, never hold.
  generate
    if (HAS_DN) begin : g_dn
      assign dn = stall_i[STAGE+1];
    end else begin : g_no_dn
      assign dn = 1'b0;
    end
  endgenerate

  assign unused_stall = ^stall_i;

  // up=0 with dn=1 cannot come from ctrl; it falls through to ADVANCE.
  always_comb begin
    act = ACT_ADVANCE;
    if (flush_i)         act = ACT_FLUSH;
    else if (up && !dn)  act = ACT_BUBBLE;
    else if (up && dn)   act = ACT_HOLD;
    else                 act = ACT_ADVANCE;
  end

  // out_valid_o qualifies out_data_o; whenever it is low the payload is NOP_VALUE.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    case (act)
      ACT_FLUSH, ACT_BUBBLE: begin
        valid_d = 1'b0;
        data_d  = NOP_VALUE;
      end
      ACT_HOLD: begin
        valid_d = valid_q;
        data_d  = data_q;
      end
      default: begin
        valid_d = in_valid_i;
        data_d  = in_valid_i ? in_data_i : NOP_VALUE;
      end
    endcase
  end

  // Clear beats a same-cycle increment; counts stick at all-ones.
  always_comb begin
    hold_cnt_d   = hold_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (cnt_clr_i) begin
      hold_cnt_d   = '0;
      bubble_cnt_d = '0;
    end else begin
      if (act == ACT_HOLD && hold_cnt_q != {CNT_W{1'b1}})
        hold_cnt_d = hold_cnt_q + CNT_W'(1);
      if (act == ACT_BUBBLE && bubble_cnt_q != {CNT_W{1'b1}})
        bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      data_q       <= NOP_VALUE;
      hold_cnt_q   <= '0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      data_q       <= data_d;
      hold_cnt_q   <= hold_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign out_valid_o  = valid_q;
  assign out_data_o   = data_q;
  assign hold_cnt_o   = hold_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;

endmodule
